// File: rtl/gppcu_issue_ctrl.sv
// GPPCU issue front-end: an input FIFO, a register scoreboard that checks RAW/WAW hazards,
// and a NUM_STAGES-deep in-order pipeline that always advances.
module gppcu_issue_ctrl #(
   parameter int DBW        = 32,
   parameter int NUM_REG    = 32,
   parameter int RBW        = 5,
   parameter int FIFO_DEPTH = 4,
   parameter int NUM_STAGES = 3,
   parameter int REGD_LSB   = 22,
   parameter int REGA_LSB   = 17,
   parameter int REGB_LSB   = 12,
   parameter bit REG0_ZERO  = 1'b1
) (
   input  logic                           iACLK,
   input  logic                           inRST,
   input  logic [DBW-1:0]                 iINSTR,
   input  logic                           iUSE_A,
   input  logic                           iUSE_B,
   input  logic                           iREGWR,
   input  logic                           iINSTR_VALID,
   output logic                           oINSTR_READY,
   input  logic                           iBUSY,
   input  logic                           iFLUSH,
   input  logic                           iCNT_CLR,
   output logic [NUM_STAGES-1:0]          oSTG_VALID,
   output logic [NUM_STAGES*DBW-1:0]      oSTG_INSTR,
   output logic                           oWB_VALID,
   output logic [RBW-1:0]                 oWB_REGD,
   output logic [$clog2(FIFO_DEPTH):0]    oFIFO_LEVEL,
   output logic [15:0]                    oHAZARD_CNT
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;

   typedef struct packed {
      logic           regwr;
      logic           use_b;
      logic           use_a;
      logic [DBW-1:0] instr;
   } entry_t;

   entry_t               fifo_mem_q [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]        level_q, level_d;
   logic [NUM_REG-1:0]   pend_q, pend_d;
   logic [NUM_STAGES-1:0] stg_valid_q, stg_valid_d;
   logic [NUM_STAGES-1:0] stg_regwr_q, stg_regwr_d;
   logic [DBW-1:0]       stg_instr_q [NUM_STAGES];
   logic [DBW-1:0]       stg_instr_d [NUM_STAGES];
   logic [15:0]          hcnt_q, hcnt_d;

   entry_t               head;
   entry_t               in_entry;
   logic                 head_valid;
   logic [RBW-1:0]       reg_a, reg_b, reg_d;
   logic                 wb_valid;
   logic [RBW-1:0]       wb_regd;
   logic [NUM_REG-1:0]   wbclear;
   logic [NUM_REG-1:0]   pend_eff;
   logic                 hazard;
   logic                 ready;
   logic                 push;
   logic                 issue;

   assign head       = fifo_mem_q[rd_ptr_q];
   assign head_valid = (level_q != '0);
   assign reg_a      = head.instr[REGA_LSB +: RBW];
   assign reg_b      = head.instr[REGB_LSB +: RBW];
   assign reg_d      = head.instr[REGD_LSB +: RBW];
   assign in_entry   = '{regwr: iREGWR, use_b: iUSE_B, use_a: iUSE_A, instr: iINSTR};

   assign wb_valid = stg_valid_q[NUM_STAGES-1] & stg_regwr_q[NUM_STAGES-1];
   assign wb_regd  = stg_instr_q[NUM_STAGES-1][REGD_LSB +: RBW];

   // A register being written back this cycle no longer blocks its readers/writers.
   always_comb begin
      wbclear = '0;
      if (wb_valid) wbclear[wb_regd] = 1'b1;
   end

   assign pend_eff = pend_q & ~wbclear;
   assign hazard   = (head.use_a & pend_eff[reg_a])
                   | (head.use_b & pend_eff[reg_b])
                   | (head.regwr & pend_eff[reg_d]);

   // Ready depends only on the current level, so a full FIFO stays not-ready during a pop.
   assign ready = (level_q != LW'(FIFO_DEPTH));
   assign push  = iINSTR_VALID & ready & ~iFLUSH;
   assign issue = head_valid & ~hazard & ~iBUSY & ~iFLUSH;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (iFLUSH) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push)  wr_ptr_d = wr_ptr_q + PW'(1);
         if (issue) rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, issue})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // Clear the written-back bit first, then set the issuing bit so a same-register set wins.
   always_comb begin
      pend_d = pend_eff;
      if (iFLUSH) begin
         pend_d = '0;
      end else if (issue && head.regwr && !(REG0_ZERO && reg_d == '0)) begin
         pend_d[reg_d] = 1'b1;
      end
   end

   always_comb begin
      stg_valid_d    = '0;
      stg_regwr_d    = '0;
      stg_valid_d[0] = issue;
      stg_regwr_d[0] = issue ? head.regwr : stg_regwr_q[0];
      stg_instr_d[0] = issue ? head.instr : stg_instr_q[0];
      for (int k = 1; k < NUM_STAGES; k++) begin
         stg_valid_d[k] = stg_valid_q[k-1];
         stg_regwr_d[k] = stg_regwr_q[k-1];
         stg_instr_d[k] = stg_instr_q[k-1];
      end
      if (iFLUSH) stg_valid_d = '0;
   end

   always_comb begin
      hcnt_d = hcnt_q;
      if (iCNT_CLR) begin
         hcnt_d = '0;
      end else if (head_valid && hazard && !iFLUSH && hcnt_q != 16'hFFFF) begin
         hcnt_d = hcnt_q + 16'd1;
      end
   end

   // NOTE: FIFO storage is not reset; the level/pointers alone decide which entries are live.
   always_ff @(posedge iACLK) begin
      if (push) fifo_mem_q[wr_ptr_q] <= in_entry;
   end

   // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge iACLK or negedge inRST) begin
      if (!inRST) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         pend_q      <= '0;
         stg_valid_q <= '0;
         stg_regwr_q <= '0;
         hcnt_q      <= '0;
         for (int k = 0; k < NUM_STAGES; k++) stg_instr_q[k] <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         pend_q      <= pend_d;
         stg_valid_q <= stg_valid_d;
         stg_regwr_q <= stg_regwr_d;
         hcnt_q      <= hcnt_d;
         for (int k = 0; k < NUM_STAGES; k++) stg_instr_q[k] <= stg_instr_d[k];
      end
   end

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stg_out
      assign oSTG_INSTR[k*DBW +: DBW] = stg_instr_q[k];
   end

   assign oINSTR_READY = ready;
   assign oSTG_VALID   = stg_valid_q;
   assign oWB_VALID    = wb_valid;
   assign oWB_REGD     = wb_regd;
   assign oFIFO_LEVEL  = level_q;
   assign oHAZARD_CNT  = hcnt_q;

endmodule

// File: tb/tb_gppcu_issue_ctrl.sv
// Self-checking bench for gppcu_issue_ctrl: an issue-order scoreboard plus per-scenario
// timing checks on stage0 valid, writeback, FIFO level/ready and the hazard counter.
module tb_gppcu_issue_ctrl;

   localparam int DBW = 32;
   localparam int NS  = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [DBW-1:0]  instr;
   logic            use_a, use_b, regwr, valid, busy, flush, cnt_clr;
   logic            ready;
   logic [NS-1:0]   stg_valid;
   logic [NS*DBW-1:0] stg_instr;
   logic            wb_valid;
   logic [4:0]      wb_regd;
   logic [2:0]      level;
   logic [15:0]     hcnt;

   int checks = 0;
   int errors = 0;
   int tag    = 0;
   logic [DBW-1:0] sb [$];

   always #5 clk = ~clk;

   gppcu_issue_ctrl dut (
      .iACLK        (clk),
      .inRST        (rst_n),
      .iINSTR       (instr),
      .iUSE_A       (use_a),
      .iUSE_B       (use_b),
      .iREGWR       (regwr),
      .iINSTR_VALID (valid),
      .oINSTR_READY (ready),
      .iBUSY        (busy),
      .iFLUSH       (flush),
      .iCNT_CLR     (cnt_clr),
      .oSTG_VALID   (stg_valid),
      .oSTG_INSTR   (stg_instr),
      .oWB_VALID    (wb_valid),
      .oWB_REGD     (wb_regd),
      .oFIFO_LEVEL  (level),
      .oHAZARD_CNT  (hcnt)
   );

   // Record accepted instructions in order; a flush discards everything still queued.
   always @(posedge clk) begin
      if (rst_n) begin
         if (flush) sb.delete();
         else if (valid && ready) sb.push_back(instr);
      end
   end

   // Every stage0 issue must be the oldest accepted instruction not yet issued.
   always @(negedge clk) begin
      if (rst_n && stg_valid[0]) begin
         logic [DBW-1:0] exp_i;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL issue_order: got %h, expected no issue (queue empty)", stg_instr[DBW-1:0]);
         end else begin
            exp_i = sb.pop_front();
            if (stg_instr[DBW-1:0] !== exp_i) begin
               errors++;
               $display("FAIL issue_order: got %h expected %h", stg_instr[DBW-1:0], exp_i);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle();
      valid = 1'b0; busy = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
      use_a = 1'b0; use_b = 1'b0; regwr = 1'b0;
   endtask

   task automatic offer(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                        input logic ua, input logic ub, input logic wr);
      tag++;
      instr = {5'd0, d, a, b, tag[11:0]};
      use_a = ua; use_b = ub; regwr = wr; valid = 1'b1;
   endtask

   task automatic drain();
      valid = 1'b0;
      repeat (6) cyc();
   endtask

   task automatic clear_cnt();
      cnt_clr = 1'b1;
      cyc();
      cnt_clr = 1'b0;
      checks++;
      if (hcnt !== 16'd0) begin errors++; $display("FAIL cnt_clear: got %0d expected 0", hcnt); end
   endtask

   task automatic test_reset();
      idle(); instr = '0; rst_n = 1'b0;
      cyc(); cyc();
      checks++; if (ready !== 1'b1)     begin errors++; $display("FAIL rst_ready: got %b expected 1", ready); end
      checks++; if (stg_valid !== '0)   begin errors++; $display("FAIL rst_stg_valid: got %b expected 0", stg_valid); end
      checks++; if (stg_instr !== '0)   begin errors++; $display("FAIL rst_stg_instr: got %h expected 0", stg_instr); end
      checks++; if (wb_valid !== 1'b0)  begin errors++; $display("FAIL rst_wb_valid: got %b expected 0", wb_valid); end
      checks++; if (wb_regd !== 5'd0)   begin errors++; $display("FAIL rst_wb_regd: got %0d expected 0", wb_regd); end
      checks++; if (level !== 3'd0)     begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
      checks++; if (hcnt !== 16'd0)     begin errors++; $display("FAIL rst_hcnt: got %0d expected 0", hcnt); end
      rst_n = 1'b1;
      cyc();
      // Reset in the middle of operation discards the queued instructions.
      busy = 1'b1;
      offer(5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      cyc();
      offer(5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      cyc();
      valid = 1'b0;
      checks++; if (level !== 3'd2) begin errors++; $display("FAIL pre_reset_level: got %0d expected 2", level); end
      rst_n = 1'b0;
      #1;
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL midop_reset_level: got %0d expected 0", level); end
      sb.delete();
      cyc();
      idle(); rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_back_to_back();
      idle();
      offer(5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 9; k++) begin
         cyc();
         checks++;
         if (stg_valid[0] !== (k >= 1 && k <= 4)) begin
            errors++; $display("FAIL b2b_stage0 k=%0d: got %b expected %b", k, stg_valid[0], (k >= 1 && k <= 4));
         end
         checks++;
         if (wb_valid !== (k >= 3 && k <= 6)) begin
            errors++; $display("FAIL b2b_wb_valid k=%0d: got %b expected %b", k, wb_valid, (k >= 3 && k <= 6));
         end
         if (k >= 3 && k <= 6) begin
            checks++;
            if (wb_regd !== 5'(k - 2)) begin
               errors++; $display("FAIL b2b_wb_regd k=%0d: got %0d expected %0d", k, wb_regd, k - 2);
            end
         end
         if (k < 3) offer(5'(k + 2), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
         else valid = 1'b0;
      end
      drain();
   endtask

   task automatic test_raw();
      idle();
      clear_cnt();
      offer(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 7; k++) begin
         cyc();
         checks++;
         if (stg_valid[0] !== (k == 1 || k == 4)) begin
            errors++; $display("FAIL raw_stage0 k=%0d: got %b expected %b", k, stg_valid[0], (k == 1 || k == 4));
         end
         if (k == 0) offer(5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
         else valid = 1'b0;
      end
      checks++; if (hcnt !== 16'd2) begin errors++; $display("FAIL raw_hcnt: got %0d expected 2", hcnt); end
      // Clear held through a hazard stall keeps the counter at zero.
      cnt_clr = 1'b1;
      offer(5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      cyc();
      offer(5'd0, 5'd0, 5'd6, 1'b0, 1'b1, 1'b0);
      cyc();
      valid = 1'b0;
      repeat (4) cyc();
      checks++; if (hcnt !== 16'd0) begin errors++; $display("FAIL clr_priority: got %0d expected 0", hcnt); end
      cnt_clr = 1'b0;
      drain();
   endtask

   task automatic test_busy();
      idle();
      busy = 1'b1;
      offer(5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         offer(5'(11 + i), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      end
      checks++; if (level !== 3'd4)  begin errors++; $display("FAIL busy_full_level: got %0d expected 4", level); end
      checks++; if (ready !== 1'b0)  begin errors++; $display("FAIL busy_full_ready: got %b expected 0", ready); end
      cyc();
      checks++; if (level !== 3'd4)  begin errors++; $display("FAIL busy_hold_level: got %0d expected 4", level); end
      checks++; if (stg_valid !== '0) begin errors++; $display("FAIL busy_no_issue: got %b expected 0", stg_valid); end
      busy = 1'b0;
      cyc();
      checks++; if (ready !== 1'b1)  begin errors++; $display("FAIL busy_ready_return: got %b expected 1", ready); end
      checks++; if (level !== 3'd3)  begin errors++; $display("FAIL busy_level_after_pop: got %0d expected 3", level); end
      checks++; if (stg_valid[0] !== 1'b1) begin errors++; $display("FAIL busy_resume: got %b expected 1", stg_valid[0]); end
      cyc();
      valid = 1'b0;
      checks++; if (level !== 3'd3)  begin errors++; $display("FAIL push_pop_level: got %0d expected 3", level); end
      repeat (4) cyc();
      drain();
   endtask

   task automatic test_reg0();
      idle();
      clear_cnt();
      offer(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         cyc();
         checks++;
         if (stg_valid[0] !== (k == 1 || k == 2)) begin
            errors++; $display("FAIL reg0_stage0 k=%0d: got %b expected %b", k, stg_valid[0], (k == 1 || k == 2));
         end
         if (k == 0) offer(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
         else valid = 1'b0;
      end
      checks++; if (hcnt !== 16'd0) begin errors++; $display("FAIL reg0_hcnt: got %0d expected 0", hcnt); end
      drain();
   endtask

   task automatic test_flush();
      idle();
      clear_cnt();
      busy = 1'b1;
      offer(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         if (i < 3) offer(5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0);
      end
      checks++; if (level !== 3'd4) begin errors++; $display("FAIL flush_fill_level: got %0d expected 4", level); end
      busy = 1'b0;
      offer(5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0);
      cyc();
      checks++; if (stg_valid[0] !== 1'b1) begin errors++; $display("FAIL flush_writer_issue: got %b expected 1", stg_valid[0]); end
      checks++; if (level !== 3'd3) begin errors++; $display("FAIL full_pop_no_push: got %0d expected 3", level); end
      cyc();
      checks++; if (level !== 3'd4) begin errors++; $display("FAIL flush_refill: got %0d expected 4", level); end
      checks++; if (stg_valid[0] !== 1'b0) begin errors++; $display("FAIL flush_raw_bubble: got %b expected 0", stg_valid[0]); end
      valid = 1'b0;
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      checks++; if (level !== 3'd0)   begin errors++; $display("FAIL flush_level: got %0d expected 0", level); end
      checks++; if (stg_valid !== '0) begin errors++; $display("FAIL flush_valids: got %b expected 0", stg_valid); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_wb: got %b expected 0", wb_valid); end
      checks++; if (hcnt !== 16'd1)   begin errors++; $display("FAIL flush_hcnt: got %0d expected 1", hcnt); end
      offer(5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0);
      cyc();
      valid = 1'b0;
      checks++; if (level !== 3'd1) begin errors++; $display("FAIL post_flush_push: got %0d expected 1", level); end
      cyc();
      checks++; if (stg_valid[0] !== 1'b1) begin errors++; $display("FAIL post_flush_issue: got %b expected 1", stg_valid[0]); end
      drain();
   endtask

   task automatic test_waw();
      idle();
      offer(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 10; k++) begin
         cyc();
         checks++;
         if (stg_valid[0] !== (k == 1 || k == 4 || k == 7)) begin
            errors++; $display("FAIL waw_stage0 k=%0d: got %b expected %b", k, stg_valid[0], (k == 1 || k == 4 || k == 7));
         end
         checks++;
         if (wb_valid !== (k == 3 || k == 6)) begin
            errors++; $display("FAIL waw_wb k=%0d: got %b expected %b", k, wb_valid, (k == 3 || k == 6));
         end
         if (k == 0)      offer(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
         else if (k == 1) offer(5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
         else             valid = 1'b0;
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_raw();
      test_busy();
      test_reg0();
      test_flush();
      test_waw();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL leftover_queue: got %0d entries expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
